quad_step_decoder: RTL and testbench

- Quadrature front end for the display counter path. Converts two raw rotary-encoder channels (a, b) into the counter control stream: a one-cycle step pulse (drives the counter's enable) plus a direction level (drives its up input, 1 = up).
- Also keeps its own wrapping position count with parallel load, mirroring the counter it feeds, so the two stay in lockstep.
- Includes input synchronisation, glitch filtering, and illegal-transition detection.

---
 rtl/quad_step_decoder.sv | 74 +++++++
 tb/tb_quad_step_decoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronised, glitch-filtered quadrature decoder with step/dir, error pulse and wrapping position.
// Build option QUAD_X1_MODE_EN selects x1 decoding (one step per full cycle); default is x4.
module quad_step_decoder #(
    parameter int FILTER_CYCLES = 4,
    parameter int POS_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a,
    input  logic                b,
    input  logic                load,
    input  logic [POS_BITS-1:0] D,
    output logic                step,
    output logic                dir,
    output logic                err,
    output logic [POS_BITS-1:0] pos,
    output logic                locked
);
    typedef enum logic {INIT, TRACK} state_t;
    state_t state;
    logic [1:0] a_sync, b_sync, s, s_prev, filt, d;
    logic [7:0] cnt;
    logic accept, fwd, rev, bad, pulse;
    function automatic logic [1:0] g2b(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction
    assign s = {a_sync[1], b_sync[1]};
    // Gray-to-binary distance: +1 forward, -1 reverse, 2 means both bits flipped
    assign d = g2b(s) - g2b(filt);
    assign fwd = d == 2'd1;
    assign rev = d == 2'd3;
    assign bad = d == 2'd2;
    assign accept = s == s_prev && cnt == 8'(FILTER_CYCLES - 1) && (state == INIT || s != filt);
`ifdef QUAD_X1_MODE_EN
    assign pulse = (fwd | rev) && s == 2'b00;
`else
    assign pulse = fwd | rev;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync <= '0;
            b_sync <= '0;
            s_prev <= '0;
            filt   <= '0;
            cnt    <= '0;
            state  <= INIT;
            step   <= 1'b0;
            dir    <= 1'b1;
            err    <= 1'b0;
            pos    <= '0;
            locked <= 1'b0;
        end else begin
            a_sync <= {a_sync[0], a};
            b_sync <= {b_sync[0], b};
            s_prev <= s;
            cnt    <= s != s_prev ? 8'd0 : cnt == 8'(FILTER_CYCLES) ? cnt : cnt + 8'd1;
            step   <= 1'b0;
            err    <= 1'b0;
            // pos follows the registered step exactly like the downstream counter
            pos    <= load ? D : step ? (dir ? pos + POS_BITS'(1) : pos - POS_BITS'(1)) : pos;
            if (accept) begin
                filt <= s;
                if (state == INIT) begin
                    state  <= TRACK;
                    locked <= 1'b1;
                end else begin
                    step <= pulse;
                    err  <= bad;
                    if (pulse) dir <= fwd;
                end
            end
        end
    end
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed checks of the default (x4, FILTER_CYCLES=4, POS_BITS=3) decoder.
module tb_quad_step_decoder;
    logic clk = 1'b0, reset = 1'b1, a = 1'b0, b = 1'b0, load = 1'b0;
    logic [2:0] D = '0;
    logic step, dir, err, locked;
    logic [2:0] pos;
    int errors = 0, checks = 0;
    int step_cnt = 0, up_cnt = 0, err_cnt = 0;
    int s0, u0, e0;
    logic found;

    quad_step_decoder #(.FILTER_CYCLES(4), .POS_BITS(3)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .load(load), .D(D),
        .step(step), .dir(dir), .err(err), .pos(pos), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step) begin
            step_cnt++;
            if (dir) up_cnt++;
        end
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic na, input logic nb, input int n);
        a = na;
        b = nb;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_step", step, 0);
        check("rst_dir", dir, 1);
        check("rst_err", err, 0);
        check("rst_pos", pos, 0);
        check("rst_locked", locked, 0);
        reset = 1'b0;
        hold(0, 0, 20);
        check("idle_locked", locked, 1);
        check("idle_steps", step_cnt, 0);
        check("idle_errs", err_cnt, 0);
        check("idle_pos", pos, 0);
        check("idle_dir", dir, 1);
        // latency: first step exactly 7 edges after the change
        hold(0, 1, 6);
        check("lat_early", step, 0);
        hold(0, 1, 1);
        check("lat_step", step, 1);
        check("lat_dir", dir, 1);
        hold(0, 1, 3);
        hold(1, 1, 10);
        hold(1, 0, 10);
        hold(0, 0, 10);
        check("fwd_steps", step_cnt, 4);
        check("fwd_up", up_cnt, 4);
        check("fwd_pos", pos, 4);
        check("fwd_err", err_cnt, 0);
        // load 0 while idle, then reverse step with wrap
        D = 3'd0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load0_pos", pos, 0);
        hold(1, 0, 10);
        check("rev_dir", dir, 0);
        check("rev_pos", pos, 7);
        for (int i = 0; i < 2; i++) begin
            hold(0, 0, 10);
            hold(0, 1, 10);
            hold(1, 1, 10);
            hold(1, 0, 10);
        end
        check("fwd8_pos", pos, 7);
        check("fwd8_dir", dir, 1);
        check("fwd8_steps", step_cnt, 13);
        hold(0, 0, 10);
        hold(0, 1, 10);
        check("pre_glitch_pos", pos, 1);
        s0 = step_cnt;
        e0 = err_cnt;
        hold(1, 1, 2);
        hold(0, 1, 12);
        check("glitch_steps", step_cnt, s0);
        check("glitch_errs", err_cnt, e0);
        check("glitch_pos", pos, 1);
        hold(1, 1, 6);
        hold(0, 1, 12);
        check("long_glitch_steps", step_cnt, s0 + 2);
        check("long_glitch_pos", pos, 1);
        hold(0, 0, 10);
        check("pre_bad_pos", pos, 0);
        s0 = step_cnt;
        e0 = err_cnt;
        u0 = up_cnt;
        hold(1, 1, 10);
        check("bad_errs", err_cnt, e0 + 1);
        check("bad_steps", step_cnt, s0);
        check("bad_pos", pos, 0);
        check("bad_dir", dir, 0);
        hold(1, 0, 10);
        check("post_bad_steps", step_cnt, s0 + 1);
        check("post_bad_up", up_cnt, u0 + 1);
        check("post_bad_pos", pos, 1);
        // load coinciding with a step wins
        a = 1'b0;
        b = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = step;
        end
        check("load_step_seen", found, 1);
        D = 3'd5;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load_pos", pos, 5);
        check("load_step_done", step, 0);
        hold(0, 0, 3);
        check("load_pos_hold", pos, 5);
        // reset in the middle of filtering
        hold(0, 1, 4);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_step", step, 0);
        check("mid_rst_dir", dir, 1);
        check("mid_rst_err", err, 0);
        check("mid_rst_pos", pos, 0);
        check("mid_rst_locked", locked, 0);
        reset = 1'b0;
        hold(0, 1, 15);
        check("relock", locked, 1);
        check("relock_pos", pos, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
